// File: rtl/phy_tx_serializer_if.sv
// Word handshake plus serial lane outputs of the two-lane transmit PHY.
interface phy_tx_serializer_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        data_out_lane0_tx;
    logic        data_out_lane1_tx;
    logic        valid_lane0_out;
    logic        valid_lane1_out;
    logic        frame_start;

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out_lane0_tx, data_out_lane1_tx,
        input  valid_lane0_out, valid_lane1_out, frame_start
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out_lane0_tx, data_out_lane1_tx,
        output valid_lane0_out, valid_lane1_out, frame_start
    );
endinterface

// File: rtl/phy_tx_serializer.sv
// Two-lane transmit PHY: buffers 32-bit words, stripes pairs across the lanes and
// shifts each lane out MSB first in 32-bit frames, filling empty frames with IDLE_CHAR.
module phy_tx_serializer #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [7:0]  IDLE_CHAR   = 8'hBC,
    parameter int          SYNC_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    phy_tx_serializer_if.slave bus
);
    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam int             CW        = PW + 1;
    localparam int             SW        = $clog2(SYNC_FRAMES + 2);
    localparam logic [31:0]    IDLE_WORD = {4{IDLE_CHAR}};
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_TWO   = CW'(2);
    localparam logic [SW-1:0]  SYNC_LAST = SW'(SYNC_FRAMES);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [4:0]    cnt;
    logic [SW-1:0] sync_cnt;
    logic [31:0]   shreg0;
    logic [31:0]   shreg1;
    logic          valid0;
    logic          valid1;
    logic          ready;
    logic          push;
    logic          load;
    logic          sync_done;
    logic [1:0]    pops;

    // Pop decision is taken from the count before this cycle, so a word pushed
    // on the load cycle waits for the next frame.
    always_comb begin
        ready     = !reset && (count < DEPTH_C);
        push      = bus.valid_in && ready;
        load      = (cnt == 5'd31);
        sync_done = (sync_cnt >= SYNC_LAST);
        rd_next   = rd_ptr + PW'(1);
        pops      = 2'd0;
        if (load && sync_done) begin
            if (count >= CNT_TWO)
                pops = 2'd2;
            else if (count == CNT_ONE)
                pops = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 5'd0;
            sync_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            shreg0   <= IDLE_WORD;
            shreg1   <= IDLE_WORD;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
        end else begin
            cnt <= cnt + 5'd1;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr + PW'(pops);
            count  <= count + CW'(push) - CW'(pops);
            if (load) begin
                if (!sync_done) begin
                    shreg0   <= IDLE_WORD;
                    shreg1   <= IDLE_WORD;
                    valid0   <= 1'b0;
                    valid1   <= 1'b0;
                    sync_cnt <= sync_cnt + SW'(1);
                end else begin
                    shreg0 <= (pops != 2'd0) ? mem[rd_ptr]  : IDLE_WORD;
                    shreg1 <= (pops == 2'd2) ? mem[rd_next] : IDLE_WORD;
                    valid0 <= (pops != 2'd0);
                    valid1 <= (pops == 2'd2);
                end
            end else begin
                shreg0 <= {shreg0[30:0], 1'b0};
                shreg1 <= {shreg1[30:0], 1'b0};
            end
        end
    end

    assign bus.ready_out         = ready;
    assign bus.frame_start       = (cnt == 5'd0) && !reset;
    assign bus.data_out_lane0_tx = shreg0[31];
    assign bus.data_out_lane1_tx = shreg1[31];
    assign bus.valid_lane0_out   = valid0;
    assign bus.valid_lane1_out   = valid1;
endmodule
